taus_rr_server: RTL

Round-robin scheduler that shares one combined Tausworthe (taus88) generator among `N_REQ` requesters. It owns the generator state and handles seeding and warm-up after reset or a seed load. Each cycle it grants at most one requester a fresh, never-reused 32-bit random word. It sits between the Tausworthe datapath and the consumer blocks, and is the only block that advances the generator.

---
 rtl/taus_pkg.sv | 35 +++
 rtl/taus88_step.sv | 20 ++
 rtl/taus_rr_server.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/taus_pkg.sv
// Shared constants, seed legality helper and FSM encoding for the taus88
// round-robin server.
package taus_pkg;

  localparam int TAUS_W = 32;

  localparam logic [TAUS_W-1:0] DEF_S1 = 32'h1234_5678;
  localparam logic [TAUS_W-1:0] DEF_S2 = 32'h9ABC_DEF0;
  localparam logic [TAUS_W-1:0] DEF_S3 = 32'hCAFE_F00D;

  localparam logic [TAUS_W-1:0] MIN_S1 = 32'd2;
  localparam logic [TAUS_W-1:0] MIN_S2 = 32'd8;
  localparam logic [TAUS_W-1:0] MIN_S3 = 32'd16;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Components below their minimum would collapse the generator, so each is
  // swapped for its default independently.
  function automatic logic [3*TAUS_W-1:0] check_seed(input logic [3*TAUS_W-1:0] seed);
    logic [TAUS_W-1:0] s1;
    logic [TAUS_W-1:0] s2;
    logic [TAUS_W-1:0] s3;
    s1 = seed[95:64];
    s2 = seed[63:32];
    s3 = seed[31:0];
    if (s1 < MIN_S1) s1 = DEF_S1;
    if (s2 < MIN_S2) s2 = DEF_S2;
    if (s3 < MIN_S3) s3 = DEF_S3;
    return {s1, s2, s3};
  endfunction

endpackage

// File: rtl/taus88_step.sv
// One combinational step of the combined Tausworthe (taus88) generator:
// next state of all three components plus the output word.
module taus88_step
  import taus_pkg::*;
(
  input  logic [TAUS_W-1:0] i_s1,
  input  logic [TAUS_W-1:0] i_s2,
  input  logic [TAUS_W-1:0] i_s3,
  output logic [TAUS_W-1:0] o_s1,
  output logic [TAUS_W-1:0] o_s2,
  output logic [TAUS_W-1:0] o_s3,
  output logic [TAUS_W-1:0] o_word
);

  assign o_s1   = ((i_s1 & 32'hFFFF_FFFE) << 12) ^ (((i_s1 << 13) ^ i_s1) >> 19);
  assign o_s2   = ((i_s2 & 32'hFFFF_FFF8) << 4)  ^ (((i_s2 << 2)  ^ i_s2) >> 25);
  assign o_s3   = ((i_s3 & 32'hFFFF_FFF0) << 17) ^ (((i_s3 << 3)  ^ i_s3) >> 11);
  assign o_word = o_s1 ^ o_s2 ^ o_s3;

endmodule

// File: rtl/taus_rr_server.sv
// Round-robin server sharing one taus88 generator among N_REQ requesters;
// owns seeding and warm-up, issues at most one fresh word per cycle.
module taus_rr_server
  import taus_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WARMUP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_load,
  input  logic [3*TAUS_W-1:0] seed_in,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    gnt,
  output logic [TAUS_W-1:0]   rnd_out,
  output logic                rnd_valid,
  output logic                busy,
  output logic                dbg_state
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP - 1);
  localparam logic [PTR_W:0]   N_EXT    = (PTR_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  state_t              r_state, w_state_nxt;
  logic [TAUS_W-1:0]   r_s1, r_s2, r_s3;
  logic [TAUS_W-1:0]   w_s1_nxt, w_s2_nxt, w_s3_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0]    r_gnt, w_gnt_nxt;
  logic [TAUS_W-1:0]   r_rnd, w_rnd_nxt;
  logic                r_rnd_valid;

  logic [TAUS_W-1:0]   w_st_s1, w_st_s2, w_st_s3, w_word;
  logic [3*TAUS_W-1:0] w_seed_chk;

  logic [2*N_REQ-1:0]  w_req2;
  logic [N_REQ-1:0]    w_rot;
  logic                w_found;
  logic [PTR_W-1:0]    w_off, w_idx, w_ptr_inc;
  logic [PTR_W:0]      w_sum;

  taus88_step u_step (
    .i_s1   (r_s1),
    .i_s2   (r_s2),
    .i_s3   (r_s3),
    .o_s1   (w_st_s1),
    .o_s2   (w_st_s2),
    .o_s3   (w_st_s3),
    .o_word (w_word)
  );

  assign w_seed_chk = check_seed(seed_in);

  // Rotate requests so bit 0 is the current pointer; the lowest set bit wins.
  assign w_req2 = {req, req} >> r_ptr;
  assign w_rot  = w_req2[N_REQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = PTR_W'(i);
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_idx     = (w_sum >= N_EXT) ? PTR_W'(w_sum - N_EXT) : w_sum[PTR_W-1:0];
  assign w_ptr_inc = (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_s1_nxt    = r_s1;
    w_s2_nxt    = r_s2;
    w_s3_nxt    = r_s3;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = '0;
    w_rnd_nxt   = r_rnd;
    if (seed_load) begin
      {w_s1_nxt, w_s2_nxt, w_s3_nxt} = w_seed_chk;
      w_cnt_nxt   = '0;
      w_state_nxt = WARM;
    end else begin
      case (r_state)
        WARM: begin
          w_s1_nxt = w_st_s1;
          w_s2_nxt = w_st_s2;
          w_s3_nxt = w_st_s3;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (w_found) begin
            w_gnt_nxt = N_REQ'(1) << w_idx;
            w_rnd_nxt = w_word;
            w_s1_nxt  = w_st_s1;
            w_s2_nxt  = w_st_s2;
            w_s3_nxt  = w_st_s3;
            w_ptr_nxt = w_ptr_inc;
          end
        end
        default: w_state_nxt = WARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WARM;
      r_s1        <= DEF_S1;
      r_s2        <= DEF_S2;
      r_s3        <= DEF_S3;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_rnd       <= '0;
      r_rnd_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s1        <= w_s1_nxt;
      r_s2        <= w_s2_nxt;
      r_s3        <= w_s3_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rnd       <= w_rnd_nxt;
      r_rnd_valid <= |w_gnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rnd_out   = r_rnd;
  assign rnd_valid = r_rnd_valid;
  assign busy      = (r_state == WARM);
  assign dbg_state = r_state;

endmodule
